square_wave_gen: RTL and testbench
==================================

SQUARE_WAVE_GEN -- requirements
Module: square_wave_gen

Interface
REQ-001 Parameter: BW, default 16, width of the half-period count and internal counter.
REQ-002 Port: clk_i  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: nrst_i  input  1  synchronous, active-low reset.
REQ-004 Port: halfCntPeriod_i  input  BW  half-period in clk_i cycles; driven by the note-to-count lookup stage (halfCntPeriod_o).
REQ-005 Port: load_i  input  1  single-cycle strobe; captures halfCntPeriod_i into the pending register.
REQ-006 Port: enable_i  input  1  level; request to play the tone.
REQ-007 Port: wave_o  output  1  registered square wave, frequency f_clk/(2*P).
REQ-008 Port: edge_o  output  1  registered pulse, high for exactly the cycle in which wave_o has just changed.
REQ-009 Port: busy_o  output  1  high whenever state is not IDLE.

Function
REQ-010 Registers: pendPeriod[BW], pendValid, activePeriod[BW] (P), cnt[BW], wave_o, edge_o, and a state register with states IDLE, RUN, STOPPING.
REQ-011 load_i=1 at an edge: pendPeriod <= halfCntPeriod_i and pendValid <= 1, in every state.
REQ-012 IDLE: wave_o=0, cnt=0; when enable_i=1 and (pendValid=1 with pendPeriod!=0, or pendValid=0 with activePeriod!=0), go to RUN and set cnt <= 0.
REQ-013 IDLE->RUN with pendValid=1 copies pendPeriod into activePeriod and clears pendValid.
REQ-014 IDLE with enable_i=1 but the effective period is 0: stay IDLE; if pendValid=1, still copy pendPeriod into activePeriod and clear pendValid.
REQ-015 RUN/STOPPING counting: if cnt==P-1, toggle wave_o, set edge_o=1 and cnt <= 0; otherwise cnt <= cnt+1 and edge_o=0.
REQ-016 Latency: with the IDLE->RUN transition at edge E, wave_o toggles at E+P, E+2P, ...
REQ-017 Toggle boundary with pendValid=1: activePeriod <= pendPeriod and pendValid cleared. The half-period then in progress always completes with the old P.
REQ-018 Same edge as a boundary transfer, load_i=1: transfer the pre-edge pendPeriod; the new value is stored with pendValid=1 for the next boundary.
REQ-019 Transfer of period 0 at a boundary (mute): wave_o <= 0 and state <= IDLE on that edge. edge_o pulses only if wave_o actually changed.
REQ-020 RUN, enable_i=0, wave_o=0: go to IDLE at the next edge, cnt <= 0, no toggle.
REQ-021 RUN, enable_i=0, wave_o=1: go to STOPPING and keep counting. At the 1->0 toggle, go to IDLE on the same edge.
REQ-022 STOPPING with enable_i=1: return to RUN without disturbing cnt, wave_o or the period.
REQ-023 P=1: wave_o toggles every cycle and edge_o stays high continuously while running.
REQ-024 Counter and compare are BW bits wide; P-1 is evaluated only for P>=1. Maximum P=2^BW-1; no wrap-around is possible.
REQ-025 edge_o=0 in IDLE, except on the stopping 1->0 edge itself.

Reset
REQ-026 nrst_i=0 at an edge: state=IDLE and wave_o, edge_o, busy_o, cnt, activePeriod, pendPeriod, pendValid all become 0, regardless of load_i and enable_i.
REQ-027 Reset asserted mid-operation (including STOPPING or wave_o=1) takes effect on the next edge. There is no drain behaviour.
REQ-028 After release, the block stays IDLE until the REQ-012 conditions hold.

Verification
REQ-029 Reset held 3 cycles with enable_i=1, load_i=1, halfCntPeriod_i=5 -> wave_o=0, edge_o=0, busy_o=0 throughout; after release, playback needs a new load.
REQ-030 load_i with halfCntPeriod_i=4, then enable_i=1 -> busy_o rises next edge; wave_o rises 4 cycles later, then toggles every 4 cycles (period 8); edge_o pulses on each toggle.
REQ-031 Running P=4; load 2 after 1 cycle of a half-period -> that half-period lasts 4 cycles, all following half-periods last 2. Load 3 coincident with a boundary while 2 is pending -> 2 is applied, 3 at the next boundary.
REQ-032 Disable at cnt=1 while wave_o=1 (P=4) -> STOPPING; wave_o falls 3 cycles later and busy_o drops on the same edge. Disable while wave_o=0 -> IDLE next edge. Re-enable in STOPPING -> seamless continuation.
REQ-033 P=1 -> wave_o alternates every cycle, edge_o constantly 1. Then load 0 -> at the next boundary wave_o=0, state IDLE, busy_o=0.
REQ-034 nrst_i=0 for 1 cycle while wave_o=1 with P=6 -> next edge all outputs 0. Re-enable after release without a load -> remains IDLE.

Source files
------------

// File: rtl/square_wave_gen.sv
// Square-wave tone generator: toggles wave_o every P clocks, with double-buffered
// period updates applied only at half-period boundaries and a clean stop on a low level.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | silent, wave_o=0, waiting for enable with a non-zero period
// RUN      | counting half-periods, wave_o toggles every P cycles
// STOPPING | enable dropped while wave_o=1; finish the high phase then go IDLE
module square_wave_gen #(
    parameter int BW = 16
) (
    input  logic          clk_i,
    input  logic          nrst_i,
    input  logic [BW-1:0] halfCntPeriod_i,
    input  logic          load_i,
    input  logic          enable_i,
    output logic          wave_o,
    output logic          edge_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] pend_period_q, pend_period_d;
    logic          pend_valid_q, pend_valid_d;
    logic [BW-1:0] active_period_q, active_period_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          wave_q, wave_d;
    logic          edge_q, edge_d;

    logic [BW-1:0] eff_period;
    logic          boundary;

    assign eff_period = pend_valid_q ? pend_period_q : active_period_q;
    // Guarding on a non-zero period keeps P-1 from ever being evaluated for P=0.
    assign boundary   = (active_period_q != '0) && (cnt_q == active_period_q - BW'(1));

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q         <= IDLE;
            pend_period_q   <= '0;
            pend_valid_q    <= 1'b0;
            active_period_q <= '0;
            cnt_q           <= '0;
            wave_q          <= 1'b0;
            edge_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            pend_period_q   <= pend_period_d;
            pend_valid_q    <= pend_valid_d;
            active_period_q <= active_period_d;
            cnt_q           <= cnt_d;
            wave_q          <= wave_d;
            edge_q          <= edge_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pend_period_d   = pend_period_q;
        pend_valid_d    = pend_valid_q;
        active_period_d = active_period_q;
        cnt_d           = cnt_q;
        wave_d          = wave_q;
        edge_d          = 1'b0;

        case (state_q)
            IDLE: begin
                wave_d = 1'b0;
                cnt_d  = '0;
                if (enable_i) begin
                    if (pend_valid_q) begin
                        active_period_d = pend_period_q;
                        pend_valid_d    = 1'b0;
                    end
                    if (eff_period != '0) begin
                        state_d = RUN;
                    end
                end
            end

            RUN, STOPPING: begin
                if ((state_q == RUN) && !enable_i && !wave_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = enable_i ? RUN : STOPPING;
                    if (boundary) begin
                        cnt_d = '0;
                        if (pend_valid_q) begin
                            active_period_d = pend_period_q;
                            pend_valid_d    = 1'b0;
                        end
                        if (pend_valid_q && (pend_period_q == '0)) begin
                            // Mute: only report an edge if the output was actually high.
                            wave_d  = 1'b0;
                            edge_d  = wave_q;
                            state_d = IDLE;
                        end else begin
                            wave_d = ~wave_q;
                            edge_d = 1'b1;
                            if (!enable_i && wave_q) begin
                                state_d = IDLE;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + BW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A fresh load always wins over the clear from a same-edge transfer.
        if (load_i) begin
            pend_period_d = halfCntPeriod_i;
            pend_valid_d  = 1'b1;
        end
    end

    assign wave_o = wave_q;
    assign edge_o = edge_q;
    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_square_wave_gen.sv
// Bench for square_wave_gen: directed scenarios plus randomized traffic, all checked
// against a remaining-cycles reference model of the tone generator.
module tb_square_wave_gen;

    localparam int BW = 16;

    logic          clk_i = 1'b0;
    logic          nrst_i;
    logic [BW-1:0] halfCntPeriod_i;
    logic          load_i;
    logic          enable_i;
    logic          wave_o;
    logic          edge_o;
    logic          busy_o;

    square_wave_gen #(.BW(BW)) dut (
        .clk_i           (clk_i),
        .nrst_i          (nrst_i),
        .halfCntPeriod_i (halfCntPeriod_i),
        .load_i          (load_i),
        .enable_i        (enable_i),
        .wave_o          (wave_o),
        .edge_o          (edge_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: playing/stopping flags and cycles left until the next toggle.
    bit m_busy, m_stop, m_wave, m_edge, m_pv;
    int m_left, m_p, m_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_step();
        bit pv0;
        int pend0;
        bit w0;
        pv0   = m_pv;
        pend0 = m_pend;
        w0    = m_wave;
        m_edge = 1'b0;
        if (!nrst_i) begin
            m_busy = 0; m_stop = 0; m_wave = 0; m_pv = 0;
            m_left = 0; m_p = 0; m_pend = 0;
        end else begin
            if (!m_busy) begin
                if (enable_i) begin
                    if (pv0) begin
                        m_p  = pend0;
                        m_pv = 0;
                    end
                    if (m_p != 0) begin
                        m_busy = 1;
                        m_stop = 0;
                        m_left = m_p;
                    end
                end
            end else if (!m_stop && !enable_i && !w0) begin
                m_busy = 0;
            end else begin
                m_stop = !enable_i;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (pv0) begin
                        m_p  = pend0;
                        m_pv = 0;
                    end
                    if (m_p == 0) begin
                        m_wave = 0;
                        m_edge = w0;
                        m_busy = 0;
                    end else begin
                        m_wave = !w0;
                        m_edge = 1;
                        m_left = m_p;
                        if (m_stop && w0) m_busy = 0;
                    end
                end
            end
            if (load_i) begin
                m_pend = int'(halfCntPeriod_i);
                m_pv   = 1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
        chk("wave", {31'd0, wave_o}, {31'd0, m_wave});
        chk("edge", {31'd0, edge_o}, {31'd0, m_edge});
        chk("busy", {31'd0, busy_o}, {31'd0, m_busy});
    endtask

    function automatic bit cond(input int mode);
        case (mode)
            0:       return m_left == 1;
            1:       return m_wave && (m_p == 4) && (m_left == 3);
            2:       return m_wave && (m_left >= 3);
            3:       return !m_wave;
            default: return m_wave;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int mode);
        int k;
        k = 0;
        while (!cond(mode) && k < 80) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, (k >= 80)}, 32'd0);
    endtask

    initial begin
        m_busy = 0; m_stop = 0; m_wave = 0; m_edge = 0; m_pv = 0;
        m_left = 0; m_p = 0; m_pend = 0;

        // Reset dominates enable and load.
        nrst_i = 1'b0; enable_i = 1'b1; load_i = 1'b1; halfCntPeriod_i = 16'd5;
        repeat (3) begin
            tick();
            chk("rst_wave", {31'd0, wave_o}, 32'd0);
            chk("rst_edge", {31'd0, edge_o}, 32'd0);
            chk("rst_busy", {31'd0, busy_o}, 32'd0);
        end
        nrst_i = 1'b1; load_i = 1'b0;
        repeat (3) begin
            tick();
            chk("noload_busy", {31'd0, busy_o}, 32'd0);
        end

        // P=4 start-up latency and steady toggling.
        enable_i = 1'b0; load_i = 1'b1; halfCntPeriod_i = 16'd4;
        tick();
        load_i = 1'b0; enable_i = 1'b1;
        tick();
        chk("p4_busy", {31'd0, busy_o}, 32'd1);
        repeat (3) begin
            tick();
            chk("p4_low", {31'd0, wave_o}, 32'd0);
        end
        tick();
        chk("p4_rise", {31'd0, wave_o}, 32'd1);
        chk("p4_rise_edge", {31'd0, edge_o}, 32'd1);
        repeat (3) begin
            tick();
            chk("p4_high", {31'd0, wave_o}, 32'd1);
            chk("p4_noedge", {31'd0, edge_o}, 32'd0);
        end
        tick();
        chk("p4_fall", {31'd0, wave_o}, 32'd0);
        chk("p4_fall_edge", {31'd0, edge_o}, 32'd1);

        // Load 2 one cycle into a half-period: the current one still lasts 4.
        tick();
        load_i = 1'b1; halfCntPeriod_i = 16'd2;
        tick();
        load_i = 1'b0;
        tick();
        chk("old_p_hold", {31'd0, wave_o}, 32'd0);
        tick();
        chk("old_p_done", {31'd0, wave_o}, 32'd1);
        tick();
        chk("p2_mid", {31'd0, edge_o}, 32'd0);
        tick();
        chk("p2_toggle", {31'd0, edge_o}, 32'd1);

        // Load 3 on a boundary while 2 is pending: 2 applies first, then 3.
        load_i = 1'b1; halfCntPeriod_i = 16'd2;
        tick();
        load_i = 1'b0;
        wait_for("wait_bnd", 0);
        load_i = 1'b1; halfCntPeriod_i = 16'd3;
        tick();
        load_i = 1'b0;
        chk("bnd_toggle", {31'd0, edge_o}, 32'd1);
        tick();
        tick();
        chk("pend2_applied", {31'd0, edge_o}, 32'd1);
        tick();
        tick();
        chk("p3_mid", {31'd0, edge_o}, 32'd0);
        tick();
        chk("pend3_applied", {31'd0, edge_o}, 32'd1);

        // Disable at cnt=1 while high with P=4: falls on the third edge, busy drops with it.
        load_i = 1'b1; halfCntPeriod_i = 16'd4;
        tick();
        load_i = 1'b0;
        wait_for("wait_hi_cnt1", 1);
        enable_i = 1'b0;
        tick();
        chk("stopping_busy", {31'd0, busy_o}, 32'd1);
        tick();
        chk("stopping_hi", {31'd0, wave_o}, 32'd1);
        tick();
        chk("stop_fall", {31'd0, wave_o}, 32'd0);
        chk("stop_edge", {31'd0, edge_o}, 32'd1);
        chk("stop_idle", {31'd0, busy_o}, 32'd0);

        // Re-enable while STOPPING continues seamlessly.
        enable_i = 1'b1;
        wait_for("wait_hi", 2);
        enable_i = 1'b0;
        tick();
        enable_i = 1'b1;
        tick();
        chk("resume_busy", {31'd0, busy_o}, 32'd1);
        repeat (10) tick();

        // Disable while low goes straight to IDLE.
        wait_for("wait_lo", 3);
        enable_i = 1'b0;
        tick();
        chk("lo_stop_busy", {31'd0, busy_o}, 32'd0);
        chk("lo_stop_edge", {31'd0, edge_o}, 32'd0);

        // P=1 then mute.
        load_i = 1'b1; halfCntPeriod_i = 16'd1;
        tick();
        load_i = 1'b0; enable_i = 1'b1;
        tick();
        repeat (5) begin
            tick();
            chk("p1_edge", {31'd0, edge_o}, 32'd1);
        end
        load_i = 1'b1; halfCntPeriod_i = 16'd0;
        tick();
        load_i = 1'b0;
        tick();
        chk("mute_wave", {31'd0, wave_o}, 32'd0);
        chk("mute_busy", {31'd0, busy_o}, 32'd0);
        repeat (2) tick();

        // Mid-run reset while high with P=6.
        enable_i = 1'b0; load_i = 1'b1; halfCntPeriod_i = 16'd6;
        tick();
        load_i = 1'b0; enable_i = 1'b1;
        wait_for("wait_p6_hi", 4);
        nrst_i = 1'b0;
        tick();
        chk("midrst_wave", {31'd0, wave_o}, 32'd0);
        chk("midrst_edge", {31'd0, edge_o}, 32'd0);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        nrst_i = 1'b1;
        repeat (4) begin
            tick();
            chk("midrst_idle", {31'd0, busy_o}, 32'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            int r;
            nrst_i = ($urandom_range(0, 299) != 0);
            load_i = ($urandom_range(0, 11) == 0);
            r = $urandom_range(0, 9);
            if (r == 0)      halfCntPeriod_i = 16'd0;
            else if (r == 1) halfCntPeriod_i = 16'd1;
            else             halfCntPeriod_i = 16'($urandom_range(2, 7));
            if ($urandom_range(0, 29) == 0) enable_i = ~enable_i;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
